com_tracker: RTL and testbench
==============================

# com_tracker

Downstream stage of the blob centroid divider. Consumes one centre-of-mass result per frame, low-pass filters it with a shift-based exponential moving average, and reports per-update velocity. Declares track loss after a run of frames with no centroid, and detects fast horizontal "thrust" motion with a cooldown. Feeds the game/scoring logic and the overlay renderer.

## Interface
- `ALPHA_SHIFT`, default 2: EMA weight = 1/2^ALPHA_SHIFT; legal range 0..4.
- `LOST_FRAMES`, default 8: consecutive frame ticks without a centroid before the track is dropped; legal range 1..255.
- `THRUST_DX`, default 40: minimum |dx| that fires a thrust; legal range 1..1023.
- `THRUST_HOLD`, default 4: number of accepted updates blocked after a thrust fires; legal range 0..15.

Ports:
- `clk_in` input 1: single clock for the block.
- `rst_in` input 1: asynchronous, active-high reset.
- `x_in` input 11: centroid x, unsigned.
- `y_in` input 10: centroid y, unsigned.
- `valid_in` input 1: one-cycle strobe; `x_in`/`y_in` are valid on this cycle.
- `frame_tick_in` input 1: one-cycle strobe per video frame.
- `x_out` output 11: filtered x.
- `y_out` output 10: filtered y.
- `dx_out` output 12: signed x change for this update.
- `dy_out` output 11: signed y change for this update.
- `valid_out` output 1: one-cycle strobe; all outputs are updated on this cycle.
- `tracking_out` output 1: a track is currently held.
- `thrust_out` output 1: one-cycle strobe coincident with `valid_out`.
- `thrust_dir_out` output 1: 1 when the thrust is toward −x; valid only while `thrust_out` is high.

## Operation
- States:
  - IDLE: no track held.
  - TRACK: a track is held.
- IDLE + `valid_in`:
  - Load filter and outputs directly from the inputs.
  - dx = dy = 0. No thrust check.
  - Clear the miss counter and cooldown. Go to TRACK.
- TRACK + `valid_in`:
  - diff = in − filt, computed signed with one extra bit (12b for x, 11b for y).
  - step = diff >>> ALPHA_SHIFT (arithmetic shift, rounds toward −inf).
  - filt ← filt + step; dx/dy_out ← step.
  - The result always lies between the old filt and the input, so no saturation is needed.
  - Clear the miss counter.
- TRACK + `frame_tick_in` without `valid_in`:
  - Increment the miss counter.
  - When the counter reaches LOST_FRAMES, go to IDLE and clear the counter and cooldown.
- `valid_in` together with `frame_tick_in`: the tick is ignored and the counter is cleared.
- `frame_tick_in` in IDLE: ignored.
- Thrust check, TRACK updates only:
  - If cooldown > 0: decrement cooldown; no fire.
  - Else if |step_x| ≥ THRUST_DX: fire. Assert `thrust_out`, set `thrust_dir_out` = sign(step_x), load cooldown = THRUST_HOLD.
- `x_out`, `y_out`, `dx_out`, `dy_out` hold their last values between strobes. After the track is lost they still show the last filtered position.

## Timing
- Reset (asynchronous, any cycle, including mid-update): all outputs are 0, state is IDLE, and filter, counter and cooldown are 0.
- Latency: `valid_out` and the updated data appear exactly 1 cycle after the `valid_in` cycle. All outputs are registered.
- `valid_in` is accepted on every cycle, back-to-back; there is no backpressure.
- `tracking_out` rises in the same cycle as the first `valid_out`.
- On loss, `tracking_out` falls 1 cycle after the LOST_FRAMES-th qualifying tick. `valid_out` is not pulsed on loss.
- `thrust_out` is high for exactly the `valid_out` cycle of the firing update.

## Configuration
- `COM_TRACKER_THRUST_EN` defined:
  - Thrust detection and the cooldown counter are built as described.
- Not defined:
  - `thrust_out` and `thrust_dir_out` are tied to 0.
  - The cooldown logic and the THRUST_DX/THRUST_HOLD comparisons are not synthesized.
  - Filter, velocity and loss behaviour are unchanged.

## Test plan
All scenarios use the default parameters.
- Reset: assert `rst_in` asynchronously mid-stream → all outputs read 0 immediately. A following `frame_tick_in` produces no `valid_out`.
- Acquire: from IDLE, (400,300) → next cycle `valid_out`=1, `x_out`=400, `y_out`=300, dx=dy=0, `tracking_out`=1.
- Filter math:
  - Then (420,300) → `x_out`=405, dx=5.
  - Then (403,300) → diff −2 gives step −1: `x_out`=404, dx=−1.
  - Then (404,310) → `y_out`=302, dy=2.
- Loss:
  - 8 `frame_tick_in` with no `valid_in` → `tracking_out` falls 1 cycle after the 8th tick.
  - Next (100,50) reinitializes to `x_out`=100, dx=0.
  - Variant: `valid_in` coincident with the 8th tick → no loss, counter cleared.
- Thrust (macro defined):
  - Filt 400, input 600 → dx=50, `thrust_out`=1, `thrust_dir_out`=0.
  - The next 4 updates with dx ≥ 40 do not fire. The 5th qualifying update fires.
  - From filt 600, input 400 → dx=−50 fires with `thrust_dir_out`=1.
- Macro undefined: repeat the thrust scenario → `thrust_out` stays 0 and the x/dx values are identical to the macro-defined run.

Source files
------------

// File: rtl/com_tracker.sv
// Centroid tracker: shift-based EMA filter, per-update velocity, track-loss timeout and
// optional thrust detector with cooldown (enabled by defining COM_TRACKER_THRUST_EN).
module com_tracker #(
  parameter int ALPHA_SHIFT = 2,
  parameter int LOST_FRAMES = 8,
  parameter int THRUST_DX   = 40,
  parameter int THRUST_HOLD = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic        [10:0] x_in,
  input  logic        [9:0]  y_in,
  input  logic               valid_in,
  input  logic               frame_tick_in,
  output logic        [10:0] x_out,
  output logic        [9:0]  y_out,
  output logic signed [11:0] dx_out,
  output logic signed [10:0] dy_out,
  output logic               valid_out,
  output logic               tracking_out,
  output logic               thrust_out,
  output logic               thrust_dir_out
);

  if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 4 || LOST_FRAMES < 1 || LOST_FRAMES > 255 ||
      THRUST_DX < 1 || THRUST_DX > 1023 || THRUST_HOLD < 0 || THRUST_HOLD > 15) begin : g_bad_cfg
    $error("com_tracker: parameter out of legal range");
  end

  localparam logic [7:0] LOST_LAST = 8'(LOST_FRAMES - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t            state, state_nxt;
  logic        [7:0] miss_cnt, miss_nxt;
  logic              drop;

  logic        [10:0] x_p1;
  logic        [9:0]  y_p1;
  logic signed [11:0] dx_p1;
  logic signed [10:0] dy_p1;
  logic               vld_p1;

  logic signed [11:0] diff_x, step_x, sum_x;
  logic signed [10:0] diff_y, step_y, sum_y;

  // Arithmetic shift rounds toward -inf, so the filter never overshoots the input.
  function automatic logic signed [11:0] ema_step(input logic signed [11:0] diff);
    return diff >>> ALPHA_SHIFT;
  endfunction

  function automatic logic signed [10:0] ema_step_y(input logic signed [10:0] diff);
    return diff >>> ALPHA_SHIFT;
  endfunction

  always_comb begin
    diff_x = $signed({1'b0, x_in}) - $signed({1'b0, x_p1});
    diff_y = $signed({1'b0, y_in}) - $signed({1'b0, y_p1});
    step_x = ema_step(diff_x);
    step_y = ema_step_y(diff_y);
    sum_x  = $signed({1'b0, x_p1}) + step_x;
    sum_y  = $signed({1'b0, y_p1}) + step_y;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    miss_nxt  = miss_cnt;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_nxt = TRACK;
          miss_nxt  = '0;
        end
      end
      TRACK: begin
        if (valid_in) begin
          miss_nxt = '0;
        end else if (frame_tick_in) begin
          if (miss_cnt == LOST_LAST) begin
            state_nxt = IDLE;
            miss_nxt  = '0;
            drop      = 1'b1;
          end else begin
            miss_nxt = miss_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered filter state doubles as the position outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_p1   <= '0;
      y_p1   <= '0;
      dx_p1  <= '0;
      dy_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= valid_in;
      if (valid_in) begin
        if (state == IDLE) begin
          x_p1  <= x_in;
          y_p1  <= y_in;
          dx_p1 <= '0;
          dy_p1 <= '0;
        end else begin
          x_p1  <= sum_x[10:0];
          y_p1  <= sum_y[9:0];
          dx_p1 <= step_x;
          dy_p1 <= step_y;
        end
      end
    end
  end

`ifdef COM_TRACKER_THRUST_EN
  localparam logic [11:0] DX_MIN = 12'(THRUST_DX);
  localparam logic [3:0]  HOLD   = 4'(THRUST_HOLD);

  logic [3:0]  cool_cnt, cool_nxt;
  logic [11:0] abs_x;
  logic        upd, fire;
  logic        thrust_p1, dir_p1;

  always_comb begin
    abs_x    = step_x[11] ? 12'(-step_x) : 12'(step_x);
    upd      = (state == TRACK) && valid_in;
    fire     = upd && (cool_cnt == 4'd0) && (abs_x >= DX_MIN);
    cool_nxt = cool_cnt;
    if ((state == IDLE && valid_in) || drop) begin
      cool_nxt = '0;
    end else if (upd) begin
      if (cool_cnt != 4'd0) cool_nxt = cool_cnt - 4'd1;
      else if (fire)        cool_nxt = HOLD;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cool_cnt  <= '0;
      thrust_p1 <= 1'b0;
      dir_p1    <= 1'b0;
    end else begin
      cool_cnt  <= cool_nxt;
      thrust_p1 <= fire;
      dir_p1    <= fire & step_x[11];
    end
  end

  assign thrust_out     = thrust_p1;
  assign thrust_dir_out = dir_p1;
`else
  assign thrust_out     = 1'b0;
  assign thrust_dir_out = 1'b0;
`endif

  assign x_out        = x_p1;
  assign y_out        = y_p1;
  assign dx_out       = dx_p1;
  assign dy_out       = dy_p1;
  assign valid_out    = vld_p1;
  assign tracking_out = (state == TRACK);

endmodule

// File: tb/tb_com_tracker.sv
// Directed bench for com_tracker with default parameters; thrust expectations follow
// whether COM_TRACKER_THRUST_EN is defined for the build.
module tb_com_tracker;

`ifdef COM_TRACKER_THRUST_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic        [10:0] x_in;
  logic        [9:0]  y_in;
  logic               valid_in;
  logic               frame_tick_in;
  logic        [10:0] x_out;
  logic        [9:0]  y_out;
  logic signed [11:0] dx_out;
  logic signed [10:0] dy_out;
  logic               valid_out;
  logic               tracking_out;
  logic               thrust_out;
  logic               thrust_dir_out;

  int n_cmp = 0;
  int n_bad = 0;

  com_tracker dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .x_in           (x_in),
    .y_in           (y_in),
    .valid_in       (valid_in),
    .frame_tick_in  (frame_tick_in),
    .x_out          (x_out),
    .y_out          (y_out),
    .dx_out         (dx_out),
    .dy_out         (dy_out),
    .valid_out      (valid_out),
    .tracking_out   (tracking_out),
    .thrust_out     (thrust_out),
    .thrust_dir_out (thrust_dir_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge with strobes cleared.
  task automatic drive(input bit v, input bit t, input int x, input int y);
    valid_in      = v;
    frame_tick_in = t;
    x_in          = 11'(x);
    y_in          = 10'(y);
    @(posedge clk_in);
    #1;
    valid_in      = 1'b0;
    frame_tick_in = 1'b0;
  endtask

  task automatic expect_upd(input string tag, input int x, input int y, input int dx,
                            input int dy, input bit thr, input bit dir);
    chk_eq({tag, ".vld"}, 32'(valid_out), 1);
    chk_eq({tag, ".x"}, 32'(x_out), x);
    chk_eq({tag, ".y"}, 32'(y_out), y);
    chk_eq({tag, ".dx"}, 32'(dx_out), dx);
    chk_eq({tag, ".dy"}, 32'(dy_out), dy);
    chk_eq({tag, ".trk"}, 32'(tracking_out), 1);
    chk_eq({tag, ".thr"}, 32'(thrust_out), 32'(thr & TE));
    if (thr && TE) chk_eq({tag, ".dir"}, 32'(thrust_dir_out), 32'(dir));
  endtask

  task automatic expect_zero(input string tag);
    chk_eq({tag, ".x"}, 32'(x_out), 0);
    chk_eq({tag, ".y"}, 32'(y_out), 0);
    chk_eq({tag, ".dx"}, 32'(dx_out), 0);
    chk_eq({tag, ".vld"}, 32'(valid_out), 0);
    chk_eq({tag, ".trk"}, 32'(tracking_out), 0);
    chk_eq({tag, ".thr"}, 32'(thrust_out), 0);
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; frame_tick_in = 1'b0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    expect_zero("por");
    rst_in = 1'b0;

    // Asynchronous reset in the middle of an update cycle.
    drive(1, 0, 100, 50);
    expect_upd("pre_rst", 100, 50, 0, 0, 0, 0);
    valid_in = 1'b1; x_in = 11'd300; y_in = 10'd60;
    #2;
    rst_in = 1'b1;
    #1;
    expect_zero("async_rst");
    valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    drive(0, 1, 0, 0);
    chk_eq("idle_tick.vld", 32'(valid_out), 0);
    chk_eq("idle_tick.trk", 32'(tracking_out), 0);

    // Acquire and filter arithmetic.
    drive(1, 0, 400, 300);
    expect_upd("acq", 400, 300, 0, 0, 0, 0);
    drive(1, 0, 420, 300);
    expect_upd("f1", 405, 300, 5, 0, 0, 0);
    drive(1, 0, 403, 300);
    expect_upd("f2", 404, 300, -1, 0, 0, 0);
    drive(1, 0, 404, 310);
    expect_upd("f3", 404, 302, 0, 2, 0, 0);
    drive(0, 0, 0, 0);
    chk_eq("strobe.vld", 32'(valid_out), 0);

    // Loss after LOST_FRAMES ticks.
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0);
    chk_eq("tick7.trk", 32'(tracking_out), 1);
    chk_eq("tick7.vld", 32'(valid_out), 0);
    drive(0, 1, 0, 0);
    chk_eq("lost.trk", 32'(tracking_out), 0);
    chk_eq("lost.vld", 32'(valid_out), 0);
    chk_eq("lost.x", 32'(x_out), 404);
    chk_eq("lost.y", 32'(y_out), 302);
    drive(1, 0, 100, 50);
    expect_upd("reacq", 100, 50, 0, 0, 0, 0);

    // valid_in coinciding with the 8th tick clears the counter instead.
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0);
    drive(1, 1, 100, 50);
    expect_upd("vt_coinc", 100, 50, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0);
    chk_eq("vt_7.trk", 32'(tracking_out), 1);
    drive(0, 1, 0, 0);
    chk_eq("vt_8.trk", 32'(tracking_out), 0);

    // Thrust with cooldown, toward +x.
    pulse_reset();
    expect_zero("rst2");
    drive(1, 0, 400, 300);
    expect_upd("t_acq", 400, 300, 0, 0, 0, 0);
    drive(1, 0, 600, 300);
    expect_upd("t_fire1", 450, 300, 50, 0, 1, 0);
    drive(1, 0, 650, 300);
    expect_upd("t_cool1", 500, 300, 50, 0, 0, 0);
    drive(1, 0, 700, 300);
    expect_upd("t_cool2", 550, 300, 50, 0, 0, 0);
    drive(1, 0, 750, 300);
    expect_upd("t_cool3", 600, 300, 50, 0, 0, 0);
    drive(1, 0, 800, 300);
    expect_upd("t_cool4", 650, 300, 50, 0, 0, 0);
    drive(1, 0, 850, 300);
    expect_upd("t_fire2", 700, 300, 50, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk_eq("t_after.thr", 32'(thrust_out), 0);

    // Thrust toward -x.
    pulse_reset();
    drive(1, 0, 600, 300);
    expect_upd("n_acq", 600, 300, 0, 0, 0, 0);
    drive(1, 0, 400, 300);
    expect_upd("n_fire", 550, 300, -50, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
